uart_mmio_decode: RTL and testbench

//  Store-side UART MMIO decoder: CPU write path into the UART, paired with the load-side status/data encoder.
//  - Decodes stores to the TX data register (0x80000008) into a small TX FIFO.
//  - Drains the FIFO to the UART transmitter over a DataIn/DataInValid/DataInReady handshake.
//  - Decodes loads of the RX data register (0x8000000c) into a one-cycle DataOutReady pop pulse to the UART receiver.

---
 rtl/uart_mmio_pkg.sv | 19 +
 rtl/uart_mmio_decode_if.sv | 13 +
 rtl/uart_tx_fifo.sv | 64 ++++++
 rtl/uart_mmio_decode.sv | 122 ++++++++++++
 tb/tb_uart_mmio_decode.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: shared UART MMIO address map and decode helper.
// Used by both the store-side decoder and the load-side status/data encoder.
package uart_mmio_pkg;

  localparam logic [31:0] UART_CTRL_ADDR     = 32'h8000_0000;
  localparam logic [31:0] UART_STAT_ADDR     = 32'h8000_0004;
  localparam logic [31:0] UART_TX_ADDR       = 32'h8000_0008;
  localparam logic [31:0] UART_RX_ADDR       = 32'h8000_000c;
  localparam logic [31:0] UART_DROP_CLR_ADDR = 32'h8000_0010;

  localparam int TX_DEPTH_DEFAULT = 4;
  localparam int TX_PTR_W_DEFAULT = 2;

  // Full 32-bit address match; no aliasing of the UART registers.
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] target);
    return (addr == target);
  endfunction

endpackage

// File: rtl/uart_mmio_decode_if.sv
// uart_mmio_decode_if: CPU memory-access bus seen by the UART MMIO decoders.
// The CPU side drives the strobes/address/data; the decoder only observes them.
interface uart_mmio_decode_if;

  logic [31:0] addr;
  logic        memWr;
  logic        memRd;
  logic [31:0] wrData;

  modport master (output addr, output memWr, output memRd, output wrData);
  modport slave  (input  addr, input  memWr, input  memRd, input  wrData);

endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small byte FIFO between the TX store decode and the output stage.
// Power-of-two depth so the read/write pointers wrap naturally; a separate
// count register (one bit wider than the pointers) distinguishes full from empty.
// Push when full and pop when empty are ignored.
module uart_tx_fifo #(
  parameter int TX_DEPTH = 4,
  parameter int TX_PTR_W = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  logic [7:0]          mem_r [TX_DEPTH];
  logic [TX_PTR_W-1:0] wr_ptr_r;
  logic [TX_PTR_W-1:0] rd_ptr_r;
  logic [TX_PTR_W:0]   count_r;
  logic [TX_PTR_W:0]   count_next_s;
  logic                push_ok_s;
  logic                pop_ok_s;

  assign full      = (count_r == (TX_PTR_W+1)'(TX_DEPTH));
  assign empty     = (count_r == (TX_PTR_W+1)'(0));
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];

  // Occupancy update: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + (TX_PTR_W+1)'(1);
      2'b01:   count_next_s = count_r - (TX_PTR_W+1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Storage, pointers and count; reset flushes every queued byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < TX_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + TX_PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + TX_PTR_W'(1);
      end
      count_r <= count_next_s;
    end
  end

endmodule

// File: rtl/uart_mmio_decode.sv
// uart_mmio_decode: store-side UART MMIO decoder.
// Stores to the TX data register queue a byte in uart_tx_fifo; a single output
// register drains the FIFO over the DataIn/DataInValid/DataInReady handshake.
// Loads of the RX data register with a byte waiting produce a registered
// one-cycle DataOutReady pop pulse.
// Optional feature macro: UART_DECODE_DROP_CNT_EN adds the dropCount port, a
// saturating count of stores lost to a full FIFO, cleared by a store to
// UART_DROP_CLR_ADDR.
module uart_mmio_decode
  import uart_mmio_pkg::*;
#(
  parameter int TX_DEPTH = TX_DEPTH_DEFAULT,
  parameter int TX_PTR_W = TX_PTR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_mmio_decode_if.slave bus,
  output logic [7:0]        DataIn,
  output logic              DataInValid,
  input  logic              DataInReady,
  input  logic              DataOutValid,
  output logic              DataOutReady,
  output logic              txNotFull,
  output logic              txIdle
`ifdef UART_DECODE_DROP_CNT_EN
  ,
  output logic [15:0]       dropCount
`endif
);

  logic       tx_sel_s;
  logic       push_s;
  logic       pop_s;
  logic       rx_pop_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;
  logic [7:0] fifo_dout_s;
  logic       unused_wr_data_s;

  // Only the low byte of store data reaches the transmitter.
  assign unused_wr_data_s = ^bus.wrData[31:8];

  // Address decode. Full is the pre-edge value, so a same-cycle pop never
  // rescues a store to a full FIFO. The stage reloads from the FIFO head only
  // when it is empty or emptying; a push into an empty FIFO is not bypassed.
  always_comb begin
    tx_sel_s = bus.memWr && addr_hit(bus.addr, UART_TX_ADDR);
    push_s   = tx_sel_s && !fifo_full_s;
    pop_s    = !fifo_empty_s && (!DataInValid || DataInReady);
    rx_pop_s = bus.memRd && addr_hit(bus.addr, UART_RX_ADDR) && DataOutValid;
  end

  uart_tx_fifo #(
    .TX_DEPTH (TX_DEPTH),
    .TX_PTR_W (TX_PTR_W)
  ) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .din     (bus.wrData[7:0]),
    .dout    (fifo_dout_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Output stage: DataIn is held while valid and not accepted; valid only
  // falls on a transfer with nothing left to reload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      DataIn      <= 8'h00;
      DataInValid <= 1'b0;
    end else if (pop_s) begin
      DataIn      <= fifo_dout_s;
      DataInValid <= 1'b1;
    end else if (DataInValid && DataInReady) begin
      DataInValid <= 1'b0;
    end else begin
      DataInValid <= DataInValid;
    end
  end

  // RX pop pulse: exactly one cycle per qualifying load cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      DataOutReady <= 1'b0;
    end else begin
      DataOutReady <= rx_pop_s;
    end
  end

  // Status outputs follow registered state with no extra latency.
  always_comb begin
    txNotFull = !fifo_full_s;
    txIdle    = fifo_empty_s && !DataInValid;
  end

`ifdef UART_DECODE_DROP_CNT_EN
  logic drop_s;
  logic drop_clr_s;

  // A store lost to a full FIFO, and the counter clear strobe.
  always_comb begin
    drop_s     = tx_sel_s && fifo_full_s;
    drop_clr_s = bus.memWr && addr_hit(bus.addr, UART_DROP_CLR_ADDR);
  end

  // Saturating drop counter; a clear coinciding with a drop restarts at one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dropCount <= 16'h0000;
    end else if (drop_clr_s) begin
      dropCount <= drop_s ? 16'h0001 : 16'h0000;
    end else if (drop_s && (dropCount != 16'hFFFF)) begin
      dropCount <= dropCount + 16'h0001;
    end else begin
      dropCount <= dropCount;
    end
  end
`endif

endmodule

// File: tb/tb_uart_mmio_decode.sv
// tb_uart_mmio_decode: self-checking bench for uart_mmio_decode.
// A negedge monitor keeps a byte scoreboard (pushed on accepted stores, popped
// on transfers) plus a small occupancy model and compares the DUT every cycle;
// a vector table covers single-cycle decode cases and hand-written sequences
// cover latency, backpressure, full drop, RX pulses, wrap and reset.
`timescale 1ns/1ps
module tb_uart_mmio_decode;
  import uart_mmio_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] DataIn;
  logic       DataInValid;
  logic       DataInReady;
  logic       DataOutValid;
  logic       DataOutReady;
  logic       txNotFull;
  logic       txIdle;
`ifdef UART_DECODE_DROP_CNT_EN
  logic [15:0] dropCount;
  int          m_drop;
`endif

  uart_mmio_decode_if bus_if ();

  uart_mmio_decode dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus_if),
    .DataIn       (DataIn),
    .DataInValid  (DataInValid),
    .DataInReady  (DataInReady),
    .DataOutValid (DataOutValid),
    .DataOutReady (DataOutReady),
    .txNotFull    (txNotFull),
    .txIdle       (txIdle)
`ifdef UART_DECODE_DROP_CNT_EN
    ,
    .dropCount    (dropCount)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         m_occ = 0;
  bit         m_stage = 1'b0;
  bit         m_rx = 1'b0;
  int         xfer_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and reference model: compare state after the last edge, then
  // advance the model by the inputs that will be sampled at the next edge.
  always @(negedge clk) begin
    bit pop_m;
    bit push_m;
    bit drop_m;
    bit clr_m;
    if (!reset_n) begin
      m_occ   = 0;
      m_stage = 1'b0;
      m_rx    = 1'b0;
      exp_q.delete();
`ifdef UART_DECODE_DROP_CNT_EN
      m_drop  = 0;
`endif
    end else begin
      check("mon_valid", DataInValid, m_stage);
      check("mon_not_full", txNotFull, (m_occ < 4));
      check("mon_idle", txIdle, (m_occ == 0) && !m_stage);
      check("mon_rx_pulse", DataOutReady, m_rx);
      if (m_stage && exp_q.size() > 0) begin
        check("mon_tx_byte", DataIn, exp_q[0]);
      end
`ifdef UART_DECODE_DROP_CNT_EN
      check("mon_drop_count", dropCount, m_drop);
`endif
      pop_m  = (m_occ > 0) && (!m_stage || DataInReady);
      push_m = bus_if.memWr && (bus_if.addr == UART_TX_ADDR) && (m_occ < 4);
      drop_m = bus_if.memWr && (bus_if.addr == UART_TX_ADDR) && (m_occ == 4);
      clr_m  = bus_if.memWr && (bus_if.addr == UART_DROP_CLR_ADDR);
      if (m_stage && DataInReady) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        xfer_cnt++;
      end
      if (push_m) exp_q.push_back(bus_if.wrData[7:0]);
      m_occ   = m_occ + int'(push_m) - int'(pop_m);
      m_stage = pop_m ? 1'b1 : ((m_stage && DataInReady) ? 1'b0 : m_stage);
      m_rx    = bus_if.memRd && (bus_if.addr == UART_RX_ADDR) && DataOutValid;
`ifdef UART_DECODE_DROP_CNT_EN
      if (clr_m) m_drop = drop_m ? 1 : 0;
      else if (drop_m && m_drop != 65535) m_drop = m_drop + 1;
`else
      if (clr_m && drop_m) m_drop_unused_dummy();
`endif
    end
  end

`ifndef UART_DECODE_DROP_CNT_EN
  function automatic void m_drop_unused_dummy();
  endfunction
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus_if.memWr  = 1'b0;
    bus_if.memRd  = 1'b0;
    bus_if.addr   = 32'h0000_0000;
    bus_if.wrData = 32'h0000_0000;
  endtask

  task automatic store(input logic [31:0] a, input logic [7:0] d);
    bus_if.memWr  = 1'b1;
    bus_if.memRd  = 1'b0;
    bus_if.addr   = a;
    bus_if.wrData = {24'hABCDEF, d};
    tick();
    bus_idle();
  endtask

  task automatic drain(input int budget);
    DataInReady = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !m_stage) break;
      tick();
    end
    check("drain_empty", exp_q.size(), 0);
    DataInReady = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [7:0]  data;
    logic        dov;
    logic        exp_rdy;
    logic        exp_idle;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int start_cnt;
    int sent;
    vecs[0] = '{UART_RX_ADDR,       1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{UART_RX_ADDR,       1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{UART_STAT_ADDR,     1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{UART_RX_ADDR,       1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{UART_TX_ADDR,       1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{UART_TX_ADDR,       1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{UART_CTRL_ADDR,     1'b0, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{UART_DROP_CLR_ADDR, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{UART_RX_ADDR,       1'b1, 1'b1, 8'h88, 1'b1, 1'b1, 1'b1};

    reset_n      = 1'b0;
    DataInReady  = 1'b0;
    DataOutValid = 1'b0;
    bus_idle();
    tick();
    tick();
    check("reset_valid", DataInValid, 1'b0);
    check("reset_not_full", txNotFull, 1'b1);
    check("reset_idle", txIdle, 1'b1);
    check("reset_rx_pulse", DataOutReady, 1'b0);
    check("reset_data", DataIn, 8'h00);
    reset_n = 1'b1;
    tick();

    // Single-cycle decode vectors.
    for (int v = 0; v < 9; v++) begin
      bus_if.addr   = vecs[v].addr;
      bus_if.memRd  = vecs[v].rd;
      bus_if.memWr  = vecs[v].wr;
      bus_if.wrData = {24'h000000, vecs[v].data};
      DataOutValid  = vecs[v].dov;
      tick();
      bus_idle();
      DataOutValid = 1'b0;
      check($sformatf("vec%0d_rx_pulse", v), DataOutReady, vecs[v].exp_rdy);
      check($sformatf("vec%0d_idle", v), txIdle, vecs[v].exp_idle);
      tick();
      check($sformatf("vec%0d_pulse_end", v), DataOutReady, 1'b0);
      drain(20);
    end

    // Single byte latency: store in cycle 0, valid in cycle 2 only.
    DataInReady = 1'b1;
    start_cnt = xfer_cnt;
    store(UART_TX_ADDR, 8'h41);
    check("single_c1_valid", DataInValid, 1'b0);
    check("single_c1_idle", txIdle, 1'b0);
    tick();
    check("single_c2_valid", DataInValid, 1'b1);
    check("single_c2_data", DataIn, 8'h41);
    tick();
    check("single_c3_valid", DataInValid, 1'b0);
    check("single_c3_idle", txIdle, 1'b1);
    check("single_count", xfer_cnt - start_cnt, 1);
    DataInReady = 1'b0;

    // Backpressure: stage plus four FIFO entries hold five bytes.
    for (int i = 0; i < 5; i++) store(UART_TX_ADDR, 8'h10 + 8'(i));
    check("bp_not_full", txNotFull, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", DataInValid, 1'b1);
      check("bp_hold_data", DataIn, 8'h10);
      tick();
    end
    DataInReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_b2b_valid", DataInValid, 1'b1);
      check("bp_b2b_data", DataIn, 8'h10 + 8'(i));
      tick();
    end
    check("bp_done_idle", txIdle, 1'b1);
    DataInReady = 1'b0;

    // Full drop with a simultaneous pop.
    for (int i = 0; i < 5; i++) store(UART_TX_ADDR, 8'h20 + 8'(i));
    start_cnt = xfer_cnt;
    DataInReady = 1'b1;
    store(UART_TX_ADDR, 8'h99);
    drain(20);
    check("drop_xfer_count", xfer_cnt - start_cnt, 5);
`ifdef UART_DECODE_DROP_CNT_EN
    check("drop_count_one", dropCount, 16'h0001);
    store(UART_DROP_CLR_ADDR, 8'h00);
    check("drop_cleared", dropCount, 16'h0000);
    for (int i = 0; i < 5; i++) store(UART_TX_ADDR, 8'h30 + 8'(i));
    bus_if.memWr = 1'b1;
    bus_if.addr  = UART_TX_ADDR;
    bus_if.wrData = 32'h0000_00EE;
    for (int i = 0; i < 65540; i++) tick();
    bus_idle();
    check("drop_saturated", dropCount, 16'hFFFF);
    drain(20);
`endif

    // Consecutive RX loads give consecutive pulses.
    bus_if.memRd = 1'b1;
    bus_if.addr  = UART_RX_ADDR;
    DataOutValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rx_consec_pulse", DataOutReady, 1'b1);
    end
    bus_idle();
    DataOutValid = 1'b0;
    tick();
    check("rx_consec_end", DataOutReady, 1'b0);

    // Wrap: 20 bytes with DataInReady toggling every cycle.
    start_cnt = xfer_cnt;
    sent = 0;
    for (int c = 0; c < 400; c++) begin
      if (sent == 20 && exp_q.size() == 0 && !m_stage) break;
      DataInReady = c[0];
      if (sent < 20 && m_occ < 4) begin
        bus_if.memWr  = 1'b1;
        bus_if.addr   = UART_TX_ADDR;
        bus_if.wrData = {24'h0, 8'h60 + 8'(sent)};
        sent++;
      end else begin
        bus_idle();
      end
      tick();
    end
    bus_idle();
    DataInReady = 1'b0;
    check("wrap_sent", sent, 20);
    check("wrap_xfer_count", xfer_cnt - start_cnt, 20);
    check("wrap_empty", exp_q.size(), 0);

    // Reset in the middle of a queued transfer, away from the clock edge.
    for (int i = 0; i < 3; i++) store(UART_TX_ADDR, 8'hC0 + 8'(i));
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_valid", DataInValid, 1'b0);
    check("midreset_not_full", txNotFull, 1'b1);
    check("midreset_idle", txIdle, 1'b1);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_reset_idle", txIdle, 1'b1);
    start_cnt = xfer_cnt;
    store(UART_TX_ADDR, 8'h77);
    drain(20);
    check("post_reset_xfer", xfer_cnt - start_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
